// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// one-cycle data_valid / frame_err strobes, ena freezes all state.
module uart_rx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             rx_s;

  assign rx_s       = sync2_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

  // State register; synchronizer resets high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and output logic; everything holds while ena is low, strobes drop
  always_comb begin
    state_d      = state_q;
    sync1_d      = sync1_q;
    sync2_d      = sync2_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    busy_d       = busy_q;

    if (ena) begin
      sync1_d = rx;
      sync2_d = sync1_q;

      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            cnt_d   = '0;
            state_d = S_START;
          end
        end

        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d = '0;
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              bit_idx_d = '0;
              state_d   = S_DATA;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d              = '0;
            shift_d[bit_idx_q] = rx_s;
            bit_idx_d          = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_d = S_STOP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d = '0;
            if (rx_s) begin
              data_out_d   = shift_q;
              data_valid_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_BREAK: begin
          if (rx_s) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase

      busy_d = (state_d != S_IDLE);
    end
  end

endmodule
